// File: rtl/loop_nest_pkg.sv
// Shared definitions for the nested down-counter loop controller.
//   N_DEF / W_DEF : default level count and per-level width
//   count_t       : one level's index/max value
//   count_vec_t   : all levels packed, level 0 in the low bits
package loop_nest_pkg;

  localparam int N_DEF = 3;
  localparam int W_DEF = 8;

  typedef logic [W_DEF-1:0]   count_t;
  typedef count_t [N_DEF-1:0] count_vec_t;

endpackage

// File: rtl/counter_down.sv
// One level of the loop nest: holds its maximum and steps max..0, then
// wraps back to max on the next step.
//   clk, rstn : clock, async active-low reset
//   load      : capture max and start at max (wins over step)
//   max       : level maximum, sampled on load
//   step      : advance this level by one beat
//   count     : current index
//   zero      : count == 0 (combinational)
module counter_down
  import loop_nest_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] max,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] max_q;

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_q <= '0;
      count <= '0;
    end else if (load) begin
      max_q <= max;
      count <= max;
    end else if (step) begin
      // decrement only while non-zero, so the count can never underflow
      count <= zero ? max_q : (count - ONE);
    end
  end

endmodule

// File: rtl/loop_nest_down.sv
// Multi-level nested down-counter. Level 0 advances on each accepted beat;
// level i advances when every level below it sits at zero. The beat that
// finds all levels at zero ends the sequence: everything reloads, busy drops
// and last_clk pulses for one cycle.
//   clk, rstn : clock, async active-low reset
//   load      : load max_in and start a sequence (priority over en)
//   max_in    : per-level maximum, level i at [i*W +: W]
//   en        : beat request, ignored while idle
//   count     : per-level index, same packing as max_in
//   last      : last[i] = levels 0..i all zero
//   busy      : sequence in progress
//   last_clk  : one-cycle pulse after the final beat
module loop_nest_down
  import loop_nest_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load,
  input  logic [N*W-1:0] max_in,
  input  logic           en,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   last,
  output logic           busy,
  output logic           last_clk
);

  logic [N-1:0][W-1:0] cnt;
  logic [N-1:0]        zero;
  logic [N-1:0]        step;
  logic                beat;

  assign beat  = en & busy & ~load;
  assign count = cnt;

  for (genvar i = 0; i < N; i++) begin : g_lvl
    // prefix-AND: a level is "last" only if it and all inner levels are zero
    if (i == 0) begin : g_inner
      assign last[i] = zero[i];
      assign step[i] = beat;
    end else begin : g_outer
      assign last[i] = last[i-1] & zero[i];
      assign step[i] = beat & last[i-1];
    end

    counter_down #(.W(W)) u_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .load  (load),
      .max   (max_in[i*W +: W]),
      .step  (step[i]),
      .count (cnt[i]),
      .zero  (zero[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= 1'b0;
      last_clk <= 1'b0;
    end else if (load) begin
      // a restart silently abandons the old sequence: no pulse
      busy     <= 1'b1;
      last_clk <= 1'b0;
    end else if (beat && last[N-1]) begin
      busy     <= 1'b0;
      last_clk <= 1'b1;
    end else begin
      last_clk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loop_nest_down.sv
module tb_loop_nest_down;

  localparam int N = 3;
  localparam int W = 8;

  typedef struct {
    logic [N*W-1:0] cnt;
    logic           busy;
    logic           lclk;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           load = 1'b0;
  logic [N*W-1:0] max_in = '0;
  logic           en = 1'b0;
  logic [N*W-1:0] count;
  logic [N-1:0]   last;
  logic           busy;
  logic           last_clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  loop_nest_down #(.N(N), .W(W)) dut (
    .clk(clk), .rstn(rstn), .load(load), .max_in(max_in), .en(en),
    .count(count), .last(last), .busy(busy), .last_clk(last_clk)
  );

  function automatic logic [N-1:0] last_of(input logic [N*W-1:0] c);
    logic [N-1:0] l;
    logic all0;
    all0 = 1'b1;
    for (int i = 0; i < N; i++) begin
      all0 = all0 & (c[i*W +: W] == '0);
      l[i] = all0;
    end
    return l;
  endfunction

  // Expected post-beat states, built by enumerating the loop nest outer-first.
  task automatic push_seq(input logic [N*W-1:0] m);
    logic [N*W-1:0] st[$];
    exp_t e;
    for (int c2 = int'(m[16 +: 8]); c2 >= 0; c2--)
      for (int c1 = int'(m[8 +: 8]); c1 >= 0; c1--)
        for (int c0 = int'(m[0 +: 8]); c0 >= 0; c0--)
          st.push_back({8'(c2), 8'(c1), 8'(c0)});
    for (int k = 1; k < st.size(); k++) begin
      e.cnt = st[k]; e.busy = 1'b1; e.lclk = 1'b0;
      sb.push_back(e);
    end
    e.cnt = m; e.busy = 1'b0; e.lclk = 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (count !== '0 || last !== 3'b111 || busy !== 1'b0 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%h last=%b busy=%b lclk=%b want 0/111/0/0", count, last, busy, last_clk);
    end
    rstn = 1'b1;
    tick();
    total++;
    if (count !== '0 || busy !== 1'b0 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL idle_en: count=%h busy=%b lclk=%b want 0/0/0", count, busy, last_clk);
    end
    en = 1'b0;
  endtask

  task automatic test_full_sequence();
    logic [N*W-1:0] m;
    exp_t e;
    m = {8'd1, 8'd2, 8'd3};
    load = 1'b1; max_in = m; en = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (count !== m || busy !== 1'b1 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL full_load: count=%h busy=%b lclk=%b want %h/1/0", count, busy, last_clk, m);
    end
    push_seq(m);
    en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || last !== last_of(e.cnt) || busy !== e.busy || last_clk !== e.lclk) begin
        bad++;
        $display("FAIL full_beat%0d: count=%h last=%b busy=%b lclk=%b want %h/%b/%b/%b",
                 k, count, last, busy, last_clk, e.cnt, last_of(e.cnt), e.busy, e.lclk);
      end
    end
    en = 1'b0;
    tick();
    total++;
    if (last_clk !== 1'b0 || busy !== 1'b0 || count !== m) begin
      bad++;
      $display("FAIL full_after: lclk=%b busy=%b count=%h want 0/0/%h", last_clk, busy, count, m);
    end
  endtask

  task automatic test_random_gaps();
    logic [N*W-1:0] m;
    logic [N*W-1:0] prev;
    exp_t e;
    int beats, cyc;
    m = {8'd1, 8'd2, 8'd3};
    for (int s = 0; s < 5; s++) begin
      load = 1'b1; max_in = m; en = 1'b0;
      tick();
      load = 1'b0;
      push_seq(m);
      prev = count;
      beats = 0; cyc = 0;
      while (sb.size() > 0 && cyc < 1000) begin
        en = ($urandom_range(0, 4) == 0);
        tick();
        cyc++;
        if (en) begin
          beats++;
          e = sb.pop_front();
          total++;
          if (count !== e.cnt || last !== last_of(e.cnt) || busy !== e.busy || last_clk !== e.lclk) begin
            bad++;
            $display("FAIL gaps_s%0d_b%0d: count=%h last=%b busy=%b lclk=%b want %h/%b/%b/%b",
                     s, beats, count, last, busy, last_clk, e.cnt, last_of(e.cnt), e.busy, e.lclk);
          end
        end else begin
          total++;
          if (count !== prev || last_clk !== 1'b0) begin
            bad++;
            $display("FAIL gaps_hold_s%0d: count=%h lclk=%b want %h/0", s, count, last_clk, prev);
          end
        end
        prev = count;
      end
      if (sb.size() > 0) begin
        total++; bad++;
        $display("FAIL gaps_timeout_s%0d: left=%0d want 0", s, sb.size());
        sb.delete();
      end
      en = 1'b0;
      tick();
      total++;
      if (last_clk !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL gaps_end_s%0d: lclk=%b busy=%b want 0/0", s, last_clk, busy);
      end
    end
  endtask

  task automatic test_degenerate();
    load = 1'b1; max_in = '0; en = 1'b0;
    tick();
    load = 1'b0;
    total++;
    if (last !== 3'b111 || busy !== 1'b1) begin
      bad++;
      $display("FAIL degen_load: last=%b busy=%b want 111/1", last, busy);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    total++;
    if (last_clk !== 1'b1 || busy !== 1'b0 || count !== '0) begin
      bad++;
      $display("FAIL degen_beat: lclk=%b busy=%b count=%h want 1/0/0", last_clk, busy, count);
    end
    tick();
    total++;
    if (last_clk !== 1'b0) begin
      bad++;
      $display("FAIL degen_pulse: lclk=%b want 0", last_clk);
    end
  endtask

  task automatic test_restart();
    logic [N*W-1:0] m2;
    exp_t e;
    load = 1'b1; max_in = {8'd1, 8'd2, 8'd3}; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    repeat (10) tick();
    m2 = {8'd0, 8'd0, 8'd5};
    load = 1'b1; max_in = m2;
    tick();
    load = 1'b0;
    total++;
    if (count !== m2 || busy !== 1'b1 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL restart_load: count=%h busy=%b lclk=%b want %h/1/0", count, busy, last_clk, m2);
    end
    push_seq(m2);
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = sb.pop_front();
      total++;
      if (count !== e.cnt || last !== last_of(e.cnt) || busy !== e.busy || last_clk !== e.lclk) begin
        bad++;
        $display("FAIL restart_beat%0d: count=%h last=%b busy=%b lclk=%b want %h/%b/%b/%b",
                 k, count, last, busy, last_clk, e.cnt, last_of(e.cnt), e.busy, e.lclk);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_collision_reset();
    logic [N*W-1:0] m2;
    load = 1'b1; max_in = {8'd1, 8'd2, 8'd3}; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    repeat (3) tick();
    m2 = {8'd2, 8'd1, 8'd0};
    load = 1'b1; max_in = m2;
    tick();
    load = 1'b0;
    total++;
    if (count !== m2 || busy !== 1'b1 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL collide: count=%h busy=%b lclk=%b want %h/1/0", count, busy, last_clk, m2);
    end
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    total++;
    if (count !== '0 || last !== 3'b111 || busy !== 1'b0 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: count=%h last=%b busy=%b lclk=%b want 0/111/0/0", count, last, busy, last_clk);
    end
    tick();
    rstn = 1'b1;
    tick();
    total++;
    if (count !== '0 || busy !== 1'b0 || last_clk !== 1'b0) begin
      bad++;
      $display("FAIL post_rst: count=%h busy=%b lclk=%b want 0/0/0", count, busy, last_clk);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_random_gaps();
    test_degenerate();
    test_restart();
    test_collision_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loop_nest_down.md
Name: loop_nest_down

Overview:
- Multi-level nested down-counter; the down-counting, nested counterpart of the single-level up-counter `counter`.
- Each level loads its own maximum and steps max..0.
- Innermost level advances on every enabled beat; each outer level advances when all levels inside it wrap.
- Drives loop indices, per-level last flags and a registered end-of-sequence pulse to the convolution/pixel loop controllers.

Parameters:
N, 3, number of nested levels (level 0 = innermost)
W, 8, bit width of each level's count/max

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
load  in  1  synchronous load of max_in; starts a new sequence
max_in  in  N*W  per-level maximum, level i at bits [i*W +: W]; level i takes max_in[i]+1 values
en  in  1  advance one beat (ignored when busy=0)
count  out  N*W  current per-level index, same packing as max_in
last  out  N  last[i]=1 when count[j]==0 for all j<=i
busy  out  1  sequence in progress
last_clk  out  1  one-cycle registered pulse on the cycle after the final beat is consumed

Behaviour:
- Reset (rstn=0, async): count=0, max regs=0, busy=0, last_clk=0.
  - last is combinational from count, so last=all ones during/after reset.
- Reset release mid-sequence: sequence is lost; a new load is required.
- load=1 (priority over en):
  - max regs <= max_in; count[i] <= max_in[i] for all i; busy <= 1; last_clk <= 0.
  - Applies even while busy (restart); no last_clk is generated for the aborted sequence.
- en=1 & busy=1 & load=0 (one beat):
  - Level 0: if count[0]!=0 then decrement, else reload to max[0].
  - Level i>0: changes only if last[i-1]=1; then decrement if !=0, else reload to max[i].
- Final beat: en & busy & last[N-1] (all counts zero).
  - All levels reload to max; busy <= 0.
  - last_clk <= 1 for exactly the next cycle.
- en while busy=0: no state change; last_clk stays 0.
- last_clk is 0 in every cycle except the one after the final beat.
- Level with max=0: contributes one value; its own zero condition is always true, but last[i] still requires all inner levels to be zero.
- All max=0: a single beat completes the sequence.
- Latency: count/last reflect a beat on the next clk edge. last is valid in the same cycle as count; no pipelining.
- Arithmetic:
  - Unsigned W-bit.
  - No underflow: decrement is only taken when the count is non-zero.
  - Total beats = product over i of (max_in[i]+1).

Decomposition:
- Package loop_nest_pkg:
  - localparam defaults for N and W.
  - typedef count_t = logic [W-1:0].
  - typedef count_vec_t = count_t [N-1:0].
- Sub-module counter_down, one instance per level via generate:
  - Inputs: clk, rstn, load, max, step.
  - Outputs: count, zero.
  - step = en & busy & (level 0 ? 1 : last[i-1]); it reloads max when zero & step.
- Top-level logic: the busy/last_clk registers and the last prefix-AND chain.

Test Plan:
1. Reset: hold rstn=0 for 3 cycles with en=1 -> count=0, last=3'b111, busy=0, last_clk=0; release, en=1 with no load -> no change.
2. Full sequence: N=3, W=8, load max_in={L2=1, L1=2, L0=3}, en=1 continuously -> 24 beats.
   - Level 0 sequence: 3,2,1,0,3,...
   - last[0] every 4th beat; last[1] every 12th beat; last[2] on beat 24.
   - last_clk=1 the single cycle after beat 24; busy=0; count back to {1,2,3}.
3. Random gaps: same load, en asserted with 20% probability -> count holds on en=0; still exactly 24 advances, then one last_clk pulse; repeat over 5 sequences.
4. Degenerate: load max_in=all 0 -> last=3'b111 immediately; one en -> last_clk next cycle, busy=0.
5. Restart: load {1,2,3}, 10 beats, then load {0,0,5} -> count={0,0,5}, busy=1, no last_clk; sequence completes after 6 further beats.
6. Collision and async reset:
   - load and en in the same cycle -> load wins, count=max, no decrement.
   - rstn pulsed low mid-sequence (between edges) -> outputs go to reset values immediately.
